// File: rtl/irq_ctrl_pkg.sv
// Shared constants, FSM state type and helpers for the interrupt request controller.
package irq_ctrl_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OFFER   = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_t;

  // One-hot vector with only bit idx set.
  function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/lowest_index_pick.sv
// Combinational lowest-set-bit finder: bit 0 has the highest priority.
module lowest_index_pick
  import irq_ctrl_pkg::*;
(
  input  logic [NUM_REQ-1:0] vec,
  output logic               any_c,
  output logic [IDX_W-1:0]   idx_c
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    any_c = |vec;
    idx_c = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx_c = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_request_controller.sv
// Latched, masked, handshaked interrupt arbitration over 8 request lines.
// Optional build macro IRQ_EDGE_DETECT_EN: pending sets on rising edges instead of levels.
module interrupt_request_controller
  import irq_ctrl_pkg::*;
(
  input  logic               Clock_In,
  input  logic               Reset_In,
  input  logic [NUM_REQ-1:0] Request_In,
  input  logic [NUM_REQ-1:0] Mask_In,
  input  logic               Ack_In,
  input  logic               Done_In,
  output logic               Valid_Out,
  output logic [IDX_W-1:0]   Vector_Out,
  output logic [NUM_REQ-1:0] Pending_Out,
  output logic [NUM_REQ-1:0] In_Service_Out,
  output logic               Busy_Out
);

  irq_state_t         state;
  irq_state_t         state_next;
  logic               valid_next;
  logic [IDX_W-1:0]   vector_next;
  logic [NUM_REQ-1:0] pending_next;
  logic [NUM_REQ-1:0] in_service_next;
  logic               busy_next;
  logic [NUM_REQ-1:0] clear_vec;
  logic [NUM_REQ-1:0] set_vec;
  logic [NUM_REQ-1:0] eligible;
  logic               win_any;
  logic [IDX_W-1:0]   win_idx;

  assign eligible = Pending_Out & ~Mask_In;

  lowest_index_pick u_pick (
    .vec   (eligible),
    .any_c (win_any),
    .idx_c (win_idx)
  );

`ifdef IRQ_EDGE_DETECT_EN
  logic [NUM_REQ-1:0] req_prev;

  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      req_prev <= '0;
    end else begin
      req_prev <= Request_In;
    end
  end

  // A fresh rising edge beats a coincident acknowledge on the same bit.
  assign set_vec      = Request_In & ~req_prev;
  assign pending_next = (Pending_Out & ~clear_vec) | set_vec;
`else
  // Level mode: the acknowledge clear wins; a held line re-sets a cycle later.
  assign set_vec      = Request_In;
  assign pending_next = (Pending_Out | set_vec) & ~clear_vec;
`endif

  // State and output registers.
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      state          <= ST_IDLE;
      Valid_Out      <= 1'b0;
      Vector_Out     <= '0;
      Pending_Out    <= '0;
      In_Service_Out <= '0;
      Busy_Out       <= 1'b0;
    end else begin
      state          <= state_next;
      Valid_Out      <= valid_next;
      Vector_Out     <= vector_next;
      Pending_Out    <= pending_next;
      In_Service_Out <= in_service_next;
      Busy_Out       <= busy_next;
    end
  end

  // Next-state and next-output logic; the offered vector is frozen outside IDLE.
  always_comb begin
    state_next      = state;
    valid_next      = Valid_Out;
    vector_next     = Vector_Out;
    in_service_next = In_Service_Out;
    clear_vec       = '0;

    unique case (state)
      ST_IDLE: begin
        if (win_any) begin
          vector_next = win_idx;
          valid_next  = 1'b1;
          state_next  = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (Ack_In) begin
          clear_vec       = idx_onehot(Vector_Out);
          in_service_next = idx_onehot(Vector_Out);
          valid_next      = 1'b0;
          state_next      = ST_SERVICE;
        end else if (Mask_In[Vector_Out]) begin
          valid_next = 1'b0;
          state_next = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (Done_In) begin
          in_service_next = '0;
          state_next      = ST_IDLE;
        end
      end
      default: begin
        valid_next      = 1'b0;
        in_service_next = '0;
        state_next      = ST_IDLE;
      end
    endcase

    busy_next = (state_next != ST_IDLE);
  end

endmodule
